// File: rtl/mem_responder.sv
// Memory-side responder: RAM, console transmit FIFO and free-running timer
// behind a single-cycle CPU port, with registered read data.
module mem_responder #(
  parameter int RAM_WORDS  = 8192,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [14:0] mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;

  localparam logic [14:0]    RAM_END     = 15'(RAM_WORDS);
  localparam logic [14:0]    ADDR_DATA   = 15'h7FF0;
  localparam logic [14:0]    ADDR_STATUS = 15'h7FF1;
  localparam logic [14:0]    ADDR_TIMER  = 15'h7FF2;
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1'b1);
  localparam logic [CW-1:0]  CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [FAW-1:0] PTR_ONE     = FAW'(1'b1);

  logic [15:0]    r_ram  [RAM_WORDS];
  logic [7:0]     r_fifo [FIFO_DEPTH];
  logic [FAW-1:0] r_wptr;
  logic [FAW-1:0] r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic [15:0]    r_timer;
  logic [15:0]    r_mem_out;

  logic           w_ram_sel;
  logic [RAW-1:0] w_ram_idx;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_push_req;
  logic           w_push;
  logic           w_ovf_set;
  logic           w_ovf_clr;
  logic           w_timer_ld;
  logic [7:0]     w_cnt8;
  logic [15:0]    w_rd_data;

  assign w_ram_sel  = (mem_addr < RAM_END);
  assign w_ram_idx  = mem_addr[RAW-1:0];
  assign w_empty    = (r_count == {CW{1'b0}});
  assign w_full     = (r_count == CNT_FULL);
  assign w_pop      = tx_valid && tx_ready;
  assign w_push_req = mem_we && (mem_addr == ADDR_DATA);
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = mem_we && (mem_addr == ADDR_STATUS) && mem_in[2];
  assign w_timer_ld = mem_we && (mem_addr == ADDR_TIMER);
  assign w_cnt8     = 8'(r_count);

  assign tx_valid = !w_empty;
  assign tx_data  = tx_valid ? r_fifo[r_rptr] : 8'h00;
  assign mem_out  = r_mem_out;

  // Read-data mux; write cycles return the same pre-edge value.
  always_comb begin
    w_rd_data = 16'h0000;
    if (w_ram_sel) begin
      w_rd_data = r_ram[w_ram_idx];
    end else begin
      case (mem_addr)
        ADDR_STATUS: w_rd_data = {w_cnt8, 5'b00000, r_ovf, w_full, w_empty};
        ADDR_TIMER:  w_rd_data = r_timer;
        default:     w_rd_data = 16'h0000;
      endcase
    end
  end

  // Backing RAM write port (contents survive reset).
  always_ff @(posedge clk) begin
    if (mem_we && w_ram_sel) begin
      r_ram[w_ram_idx] <= mem_in;
    end
  end

  // FIFO storage; stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= mem_in[7:0];
    end
  end

  // Registered read data, FIFO control, overflow flag and timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_out <= 16'h0000;
      r_wptr    <= {FAW{1'b0}};
      r_rptr    <= {FAW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_ovf     <= 1'b0;
      r_timer   <= 16'h0000;
    end else begin
      r_mem_out <= w_rd_data;
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_timer <= w_timer_ld ? mem_in : (r_timer + 16'h0001);
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the CPU's single-port memory interface (`mem_we`, 15-bit word address, 16-bit data each way). Decodes each access to backing RAM, a console transmit FIFO, or a free-running timer, and returns read data with fixed one-cycle latency. The CPU port has no wait or handshake, so every access completes on the clock edge where it is presented. The console FIFO drains through a valid/ready byte stream to the board-level transmitter.

## Interface
- `RAM_WORDS`, 8192: RAM size in 16-bit words. Power of two, at most 0x7FF0.
- `FIFO_DEPTH`, 8: console FIFO entries. Power of two, 2..128.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_we`  in  1  write strobe from the CPU; the write commits at the rising edge.
- `mem_addr`  in  15  word address from the CPU.
- `mem_in`  in  16  write data from the CPU.
- `mem_out`  out  16  registered read data returned to the CPU.
- `tx_valid`  out  1  the console FIFO holds a byte.
- `tx_data`  out  8  FIFO head byte; 0x00 when empty.
- `tx_ready`  in  1  the downstream transmitter accepts `tx_data` this cycle.

## Operation
- Address map (word addresses):
  - 0x0000..RAM_WORDS-1: RAM.
  - RAM_WORDS..0x7FEF: unmapped. Reads return 0x0000; writes are ignored.
  - 0x7FF0 CON_DATA: a write pushes `mem_in[7:0]`. A read returns 0x0000.
  - 0x7FF1 CON_STATUS: read layout:
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [7:3] zero
    - [15:8] fill count, zero-extended
    - A write with `mem_in[2]`=1 clears overflow; all other write bits are ignored.
  - 0x7FF2 TIMER: a read returns the counter value. A write loads `mem_in`.
  - 0x7FF3..0x7FFF: reserved. Reads return 0x0000; writes are ignored.
- RAM: one read or write port per cycle. Contents are not cleared by reset and are undefined after power-up.
- Read-during-write to the same RAM word is read-first: `mem_out` shows the old value.
- FIFO push to CON_DATA:
  - Not full: the byte is appended and the count increments.
  - Full and no pop this cycle: the byte is dropped and overflow is set.
  - Full with a pop in the same cycle: the push is accepted and the count is unchanged.
- FIFO pop occurs when `tx_valid && tx_ready`; the head advances and the count decrements.
- Push and pop in the same non-full cycle: the count is unchanged and ordering is preserved.
- Read and write pointers wrap modulo FIFO_DEPTH.
- `tx_valid` = count != 0. `tx_data` = head entry when valid, else 0x00. Both are combinational from FIFO state, so `tx_valid` asserts the cycle after the first push edge.
- TIMER increments by 1 every cycle and wraps 0xFFFF→0x0000.
  - A write loads `mem_in` at the edge, replacing that cycle's increment.
  - The next cycle's read sees `mem_in`; the counter then continues from that value.
- Reads have no side effects; only writes change state.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `mem_out`=0x0000, count=0, pointers=0, overflow=0, TIMER=0x0000.
  - Therefore `tx_valid`=0 and `tx_data`=0x00.
  - Reset mid-operation discards FIFO contents and any pending `tx` beat. RAM is untouched.
- Read latency is one cycle. Address A presented in cycle N (`mem_we`=0) produces `mem_out`=data(A) throughout cycle N+1.
- `mem_out` holds its value until the next edge. The CPU may issue back-to-back accesses every cycle.
- Write cycles also update `mem_out`:
  - RAM addresses: the old RAM word.
  - MMIO addresses: the pre-edge register value (CON_STATUS, TIMER) or 0x0000 (CON_DATA, unmapped).
- Status and timer reads reflect state sampled at the edge, before that edge's push, pop, or increment.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset, then write 0xBEEF to 0x0010, then read 0x0010 → `mem_out`=0xBEEF exactly one cycle after the read address. A read of 0x7000 → 0x0000.
- Write 0x1234 then 0x5678 to 0x0020 in consecutive cycles → the second cycle's `mem_out`=0x1234 (read-first). A subsequent read → 0x5678.
- With `tx_ready`=0, push 0x41..0x48, then push 0x49 → status=0x0806 (count 8, full, overflow). With `tx_ready`=1, bytes drain 0x41..0x48 in order, then `tx_valid`=0. Write 0x0004 to status → status=0x0001.
- Full FIFO with `tx_ready`=1: push 0x5A in the same cycle as a pop → count stays 8, overflow stays 0, and 0x5A exits last.
- Write 0xFFFE to TIMER, then read it on each of the next three cycles → 0xFFFE, 0xFFFF, 0x0000.
- Assert `rst_n`=0 mid-drain with 3 bytes queued → `tx_valid`, `mem_out`, and TIMER clear immediately without a clock edge. A previously written RAM word still reads back its value.
